// File: rtl/xaui_lane_sync.sv
// xaui_lane_sync: receive-side lane synchroniser for the 4-lane, 2-byte/lane MGT interface.
//   clk              in   receive clock, all logic on posedge
//   reset            in   synchronous active-high reset
//   mgt_rxlock       in   [3:0] per-lane CDR lock, low forces lane to LOS
//   mgt_rx_reset     in   [3:0] per-lane MGT rx reset, high forces lane to LOS
//   mgt_codecomma    in   [7:0] lane n on [2n+1:2n], 1 = K28.5
//   mgt_codevalid    in   [7:0] lane n on [2n+1:2n], 0 = code violation
//   mgt_enable_align out  [3:0] per-lane comma-align enable
//   mgt_enchansync   out  channel-bonding enable, all lanes in sync
//   sync_status      out  [3:0] per-lane in-sync flag
//   err_count_dbg    out  [15:0] lane n error count on [4n+3:4n]
module xaui_lane_sync #(
    parameter int COMMA_TARGET = 4,
    parameter int ERR_LIMIT    = 4,
    parameter int GOOD_RUN     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mgt_rxlock,
    input  logic [3:0]  mgt_rx_reset,
    input  logic [7:0]  mgt_codecomma,
    input  logic [7:0]  mgt_codevalid,
    output logic [3:0]  mgt_enable_align,
    output logic        mgt_enchansync,
    output logic [3:0]  sync_status,
    output logic [15:0] err_count_dbg
);
    typedef enum logic [1:0] {LOS = 2'd0, DETECT = 2'd1, SYNC = 2'd2} state_t;
    localparam logic [3:0] CT = 4'(COMMA_TARGET);
    localparam logic [3:0] EL = 4'(ERR_LIMIT);
    localparam logic [3:0] GR = 4'(GOOD_RUN);
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : lane
            state_t     st, st_n;
            logic [3:0] cc, cc_n, ec, ec_n, gc, gc_n;
            logic       inv, comma, frc, sync_q, align_q;
            assign inv   = ~&mgt_codevalid[2*g+1:2*g];
            assign comma = |mgt_codecomma[2*g+1:2*g] & ~inv;
            assign frc   = reset | ~mgt_rxlock[g] | mgt_rx_reset[g];
            always_comb begin
                st_n = st;
                cc_n = cc;
                ec_n = ec;
                gc_n = gc;
                if (frc) begin
                    st_n = LOS;
                    cc_n = '0;
                    ec_n = '0;
                    gc_n = '0;
                end else if (st == LOS) begin
                    if (comma) begin
                        st_n = (CT == 4'd1) ? SYNC : DETECT;
                        cc_n = (CT == 4'd1) ? 4'd0 : 4'd1;
                    end
                end else if (st == DETECT) begin
                    if (inv) begin
                        st_n = LOS;
                        cc_n = '0;
                    end else if (comma) begin
                        st_n = (cc + 4'd1 == CT) ? SYNC : DETECT;
                        cc_n = (cc + 4'd1 == CT) ? 4'd0 : cc + 4'd1;
                        ec_n = '0;
                        gc_n = '0;
                    end
                end else if (st == SYNC) begin
                    // An invalid cycle always beats a completing good run.
                    if (inv) begin
                        st_n = (ec + 4'd1 == EL) ? LOS : SYNC;
                        ec_n = (ec + 4'd1 == EL) ? 4'd0 : ec + 4'd1;
                        gc_n = '0;
                        cc_n = '0;
                    end else if (ec != 4'd0) begin
                        ec_n = (gc + 4'd1 == GR) ? ec - 4'd1 : ec;
                        gc_n = (gc + 4'd1 == GR) ? 4'd0 : gc + 4'd1;
                    end else begin
                        gc_n = '0;
                    end
                end else begin
                    st_n = LOS;
                    cc_n = '0;
                    ec_n = '0;
                    gc_n = '0;
                end
            end
            always_ff @(posedge clk) begin
                st      <= st_n;
                cc      <= cc_n;
                ec      <= ec_n;
                gc      <= gc_n;
                sync_q  <= (st_n == SYNC);
                align_q <= (st_n != SYNC);
            end
            assign sync_status[g]           = sync_q;
            assign mgt_enable_align[g]      = align_q;
            assign err_count_dbg[4*g+3:4*g] = ec;
        end
    endgenerate
    always_ff @(posedge clk) begin
        mgt_enchansync <= reset ? 1'b0 : &sync_status;
    end
endmodule

// File: tb/tb_xaui_lane_sync.sv
// tb_xaui_lane_sync: directed-vector scoreboard bench for xaui_lane_sync
module tb_xaui_lane_sync;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  lock = 4'h0, rxr = 4'h0;
  logic [7:0]  cc = 8'h00, cv = 8'hFF;
  logic [3:0]  align, ss;
  logic        en;
  logic [15:0] err;
  typedef struct {
    logic        chk;
    logic [3:0]  ss;
    logic        en;
    logic [15:0] err;
    int          id;
  } exp_t;
  exp_t q[$];
  exp_t m;
  logic bad;
  int checks = 0, errors = 0, vec = 0;
  always #5 clk = ~clk;
  xaui_lane_sync dut (
    .clk(clk), .reset(reset), .mgt_rxlock(lock), .mgt_rx_reset(rxr),
    .mgt_codecomma(cc), .mgt_codevalid(cv), .mgt_enable_align(align),
    .mgt_enchansync(en), .sync_status(ss), .err_count_dbg(err)
  );
  task automatic step(input logic chk, input logic [3:0] s, input logic e, input logic [15:0] r);
    exp_t x;
    @(posedge clk);
    x.chk = chk; x.ss = s; x.en = e; x.err = r; x.id = vec++;
    q.push_back(x);
    @(negedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      m = q.pop_front();
      if (m.chk) begin
        checks++;
        bad = 1'b0;
        if (ss !== m.ss) bad = 1'b1;
        if (align !== ~m.ss) bad = 1'b1;
        if (en !== m.en) bad = 1'b1;
        if (err !== m.err) bad = 1'b1;
        if (bad) begin
          errors++;
          $display("FAIL vec%0d: got ss=%h align=%h en=%b err=%h, want ss=%h align=%h en=%b err=%h",
                   m.id, ss, align, en, err, m.ss, ~m.ss, m.en, m.err);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (3) step(1, 4'h0, 1'b0, 16'h0);
    reset = 1'b0; lock = 4'hF; cc = 8'h55;
    repeat (3) step(1, 4'h0, 1'b0, 16'h0);
    step(1, 4'hF, 1'b0, 16'h0);
    repeat (2) step(1, 4'hF, 1'b1, 16'h0);
    reset = 1'b1; step(0, 4'h0, 1'b0, 16'h0);
    reset = 1'b0; step(1, 4'h0, 1'b0, 16'h0);
    cv = 8'hCF; step(1, 4'h0, 1'b0, 16'h0);
    cv = 8'hFF; step(1, 4'h0, 1'b0, 16'h0);
    repeat (2) step(1, 4'hB, 1'b0, 16'h0);
    step(1, 4'hF, 1'b0, 16'h0);
    step(1, 4'hF, 1'b1, 16'h0);
    cv = 8'hF3;
    step(1, 4'hF, 1'b1, 16'h0010);
    step(1, 4'hF, 1'b1, 16'h0020);
    step(1, 4'hF, 1'b1, 16'h0030);
    cv = 8'hFF;
    repeat (3) step(1, 4'hF, 1'b1, 16'h0030);
    repeat (4) step(1, 4'hF, 1'b1, 16'h0020);
    repeat (4) step(1, 4'hF, 1'b1, 16'h0010);
    step(1, 4'hF, 1'b1, 16'h0000);
    cv = 8'hF3;
    step(1, 4'hF, 1'b1, 16'h0010);
    step(1, 4'hF, 1'b1, 16'h0020);
    step(1, 4'hF, 1'b1, 16'h0030);
    step(1, 4'hD, 1'b1, 16'h0000);
    cv = 8'hFF;
    repeat (3) step(1, 4'hD, 1'b0, 16'h0);
    step(1, 4'hF, 1'b0, 16'h0);
    step(1, 4'hF, 1'b1, 16'h0);
    lock = 4'h7; step(1, 4'h7, 1'b1, 16'h0);
    lock = 4'hF;
    repeat (3) step(1, 4'h7, 1'b0, 16'h0);
    step(1, 4'hF, 1'b0, 16'h0);
    step(1, 4'hF, 1'b1, 16'h0);
    rxr = 4'h1; step(1, 4'hE, 1'b1, 16'h0);
    rxr = 4'h0;
    repeat (3) step(1, 4'hE, 1'b0, 16'h0);
    step(1, 4'hF, 1'b0, 16'h0);
    step(1, 4'hF, 1'b1, 16'h0);
    cv = 8'hFC; step(1, 4'hF, 1'b1, 16'h0001);
    cv = 8'hFF; repeat (3) step(1, 4'hF, 1'b1, 16'h0001);
    cv = 8'hFC; step(1, 4'hF, 1'b1, 16'h0002);
    cv = 8'hFF; repeat (3) step(1, 4'hF, 1'b1, 16'h0002);
    step(1, 4'hF, 1'b1, 16'h0001);
    reset = 1'b1;
    step(1, 4'h0, 1'b0, 16'h0);
    step(1, 4'h0, 1'b0, 16'h0);
    reset = 1'b0;
    if (errors != 0) $display("FAIL: %0d of %0d checks failed", errors, checks);
    else $display("PASS: %0d checks", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
